// File: rtl/cn_pkg.sv
// Shared widths and types for the CN frame loader and its neighbours.
// The loader's parameters default to these values.
package cn_pkg;

   localparam int CN_DATA_W  = 4;
   localparam int CN_OP_W    = 5;
   localparam int CN_RES_W   = 9;
   localparam int CN_NUM_OPS = 6;

   typedef enum logic [1:0] {S_OP, S_NUM, S_EVAL, S_OUT} cn_ld_state_t;
   typedef logic [CN_DATA_W-1:0] cn_operand_t;

endpackage

// File: rtl/cn_frame_loader.sv
// Collects one opcode beat plus NUM_OPS operand beats and holds them stable for CN.
// It then captures the CN result and offers it on a valid/ready result port.
module cn_frame_loader
   import cn_pkg::*;
#(
   parameter int DATA_W  = CN_DATA_W,
   parameter int OP_W    = CN_OP_W,
   parameter int RES_W   = CN_RES_W,
   parameter int NUM_OPS = CN_NUM_OPS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
   // The source holds its payload until then; ready never depends on valid.
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   in_data,
   output logic [OP_W-1:0]   cn_opcode,
   output logic [DATA_W-1:0] cn_in_n0,
   output logic [DATA_W-1:0] cn_in_n1,
   output logic [DATA_W-1:0] cn_in_n2,
   output logic [DATA_W-1:0] cn_in_n3,
   output logic [DATA_W-1:0] cn_in_n4,
   output logic [DATA_W-1:0] cn_in_n5,
   input  logic [RES_W-1:0]  cn_out_n,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [RES_W-1:0]  out_data,
   output cn_ld_state_t      state
);

   localparam int IDX_W = $clog2(NUM_OPS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS - 1);

   cn_ld_state_t      state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [OP_W-1:0]   opcode_q;
   cn_operand_t       ops_q [NUM_OPS];
   logic [RES_W-1:0]  out_data_q;
   logic              out_valid_q, out_valid_d;

   logic              take_beat;
   logic              load_op;
   logic              load_num;
   logic              capture;
   logic              clear_regs;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      out_valid_d = out_valid_q;
      take_beat   = 1'b0;
      load_op     = 1'b0;
      load_num    = 1'b0;
      capture     = 1'b0;
      clear_regs  = 1'b0;

      if (flush) begin
         state_d     = S_OP;
         idx_d       = '0;
         out_valid_d = 1'b0;
         clear_regs  = 1'b1;
      end else begin
         case (state_q)
            S_OP: begin
               take_beat = 1'b1;
               if (in_valid) begin
                  load_op = 1'b1;
                  idx_d   = '0;
                  state_d = S_NUM;
               end
            end
            S_NUM: begin
               take_beat = 1'b1;
               if (in_valid) begin
                  load_num = 1'b1;
                  if (idx_q == LAST_IDX) begin
                     idx_d   = '0;
                     state_d = S_EVAL;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end
            end
            S_EVAL: begin
               capture     = 1'b1;
               out_valid_d = 1'b1;
               state_d     = S_OUT;
            end
            S_OUT: begin
               // After the handshake we stay here one more cycle with out_valid low,
               // so in_ready returns one cycle after the result leaves.
               if (!out_valid_q) begin
                  state_d = S_OP;
               end else if (out_ready) begin
                  out_valid_d = 1'b0;
               end
            end
            default: begin
               state_d = S_OP;
               idx_d   = '0;
            end
         endcase
      end
   end

   assign in_ready = take_beat & ~rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_OP;
         idx_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Frame registers change only on their own beat or on flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opcode_q <= '0;
         for (int i = 0; i < NUM_OPS; i++) begin
            ops_q[i] <= '0;
         end
      end else if (clear_regs) begin
         opcode_q <= '0;
         for (int i = 0; i < NUM_OPS; i++) begin
            ops_q[i] <= '0;
         end
      end else if (load_op) begin
         opcode_q <= in_data;
      end else if (load_num) begin
         ops_q[idx_q] <= in_data[DATA_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data_q <= '0;
      end else if (capture) begin
         out_data_q <= cn_out_n;
      end
   end

   assign cn_opcode = opcode_q;
   assign cn_in_n0  = ops_q[0];
   assign cn_in_n1  = ops_q[1];
   assign cn_in_n2  = ops_q[2];
   assign cn_in_n3  = ops_q[3];
   assign cn_in_n4  = ops_q[4];
   assign cn_in_n5  = ops_q[5];
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign state     = state_q;

endmodule
